reg_to_obi_bridge: RTL

- Register-interface target that turns each reg_bus request into one OBI initiator transaction. It is the opposite direction of the OBI-to-register path in the peripheral subsystem.
- Lets register-bus masters, such as debug or config sequencers, reach OBI slaves (memory banks, AO peripherals) through a single outstanding-transaction FSM.
- Has an optional response timeout with orphan-response tracking.

---
 rtl/reg_to_obi_bridge.sv | 134 +++++++++++++
 1 files changed

// File: rtl/reg_to_obi_bridge.sv
// reg_to_obi_bridge: reg_bus target issuing one OBI transaction per request; REG_TO_OBI_TIMEOUT_EN adds timeout/orphan tracking
module reg_to_obi_bridge #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ORPHAN_MAX = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            reg_valid_i,
  input  logic            reg_write_i,
  input  logic [AW-1:0]   reg_addr_i,
  input  logic [DW-1:0]   reg_wdata_i,
  input  logic [DW/8-1:0] reg_wstrb_i,
  output logic            reg_ready_o,
  output logic [DW-1:0]   reg_rdata_o,
  output logic            reg_error_o,
  output logic            obi_req_o,
  input  logic            obi_gnt_i,
  output logic [AW-1:0]   obi_addr_o,
  output logic            obi_we_o,
  output logic [DW/8-1:0] obi_be_o,
  output logic [DW-1:0]   obi_wdata_o,
  input  logic            obi_rvalid_i,
  input  logic [DW-1:0]   obi_rdata_i
);
  localparam int BW = DW / 8;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic we_q, we_d;
  logic [BW-1:0] be_q, be_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic err_q, err_d;
  logic accept, rsp_ok, expired;
`ifdef REG_TO_OBI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int OW = $clog2(ORPHAN_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] orphan_q, orphan_d;
  logic discard, orphan_inc;
  // Responses are in order, so the oldest ones belong to timed-out transactions.
  assign discard = obi_rvalid_i && orphan_q != '0;
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign accept = reg_valid_i && orphan_q != OW'(ORPHAN_MAX);
  assign rsp_ok = obi_rvalid_i && !discard;
  assign orphan_inc = state_q == RESP && !rsp_ok && expired;
  always_comb begin
    cnt_d = (state_q == REQ || state_q == RESP) ? cnt_q + 1'b1 : '0;
    orphan_d = orphan_q;
    if (orphan_inc && !discard)
      orphan_d = orphan_q == OW'(ORPHAN_MAX) ? orphan_q : orphan_q + 1'b1;
    else if (discard && !orphan_inc)
      orphan_d = orphan_q - 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      orphan_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      orphan_q <= orphan_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(TIMEOUT_CYCLES), 32'(ORPHAN_MAX)};
  assign expired = 1'b0;
  assign accept = reg_valid_i;
  assign rsp_ok = obi_rvalid_i;
`endif
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    we_d = we_q;
    be_d = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = REQ;
        addr_d = reg_addr_i;
        we_d = reg_write_i;
        be_d = reg_write_i ? reg_wstrb_i : '1;
        wdata_d = reg_write_i ? reg_wdata_i : '0;
      end
      // rvalid alongside gnt violates OBI and is not looked at here.
      REQ: if (obi_gnt_i) state_d = RESP;
        else if (expired) begin
          state_d = DONE;
          rdata_d = '0;
          err_d = 1'b1;
        end
      RESP: if (rsp_ok) begin
          state_d = DONE;
          rdata_d = we_q ? '0 : obi_rdata_i;
          err_d = 1'b0;
        end else if (expired) begin
          state_d = DONE;
          rdata_d = '0;
          err_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      be_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign obi_req_o = state_q == REQ;
  assign obi_addr_o = addr_q;
  assign obi_we_o = we_q;
  assign obi_be_o = be_q;
  assign obi_wdata_o = wdata_q;
  assign reg_ready_o = state_q == DONE;
  assign reg_rdata_o = reg_ready_o ? rdata_q : '0;
  assign reg_error_o = reg_ready_o && err_q;
endmodule
